// File: rtl/comb_pkg.sv
// rtl/comb_pkg.sv - shared constants for the combinational-circuit self-test controller
package comb_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Number of input codes swept per run
  localparam int VEC_N = 8;

  // Expected {F1,F2,F3} for each {x,y,z}; code 7 lives in bits [23:21]
  localparam logic [3*VEC_N-1:0] GOLDEN = 24'hA62485;

endpackage

// File: rtl/comb_golden_rom.sv
// rtl/comb_golden_rom.sv - combinational lookup of expected {F1,F2,F3} per input code
module comb_golden_rom
  import comb_pkg::*;
(
  input  logic [2:0] idx,
  output logic [2:0] expected
);

  // Slice the packed golden table at the current code
  always_comb begin
    expected = GOLDEN[3*int'(idx) +: 3];
  end

endmodule

// File: rtl/comb_self_test.sv
// rtl/comb_self_test.sv - self-test sweep, compare and result capture for a 3-in/3-out circuit
module comb_self_test
  import comb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] f,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail_idx
);

  // Counter wide enough to hold SETTLE_CYCLES after its final increment
  localparam int              CW       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]      VEC_LAST = 3'(VEC_N - 1);

  logic [1:0]    state;
  logic [2:0]    vec;
  logic [CW-1:0] cnt;
  logic [2:0]    expected;
  logic          mismatch;

  comb_golden_rom u_golden_rom (
    .idx      (vec),
    .expected (expected)
  );

  // Compare the circuit response against the golden entry for the driven code
  always_comb begin
    mismatch = (f != expected);
  end

  // Sweep FSM plus vector, settle counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      vec            <= 3'd0;
      cnt            <= '0;
      err_count      <= 4'd0;
      fail_valid     <= 1'b0;
      first_fail_idx <= 3'd0;
    end else if (abort) begin
      state          <= ST_IDLE;
      vec            <= 3'd0;
      cnt            <= '0;
      err_count      <= 4'd0;
      fail_valid     <= 1'b0;
      first_fail_idx <= 3'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_SETTLE;
            vec            <= 3'd0;
            cnt            <= '0;
            err_count      <= 4'd0;
            fail_valid     <= 1'b0;
            first_fail_idx <= 3'd0;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 4'd1;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= vec;
            end
          end
          // The last code parks the vector at 7; wrap only happens on restart
          if (vec == VEC_LAST) begin
            state <= ST_DONE;
          end else begin
            vec   <= vec + 3'd1;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from state and the registered results
  always_comb begin
    {x, y, z} = vec;
    busy      = (state == ST_SETTLE) || (state == ST_CHECK);
    done      = (state == ST_DONE);
    pass      = done && (err_count == 4'd0);
  end

endmodule

// File: tb/tb_comb_self_test.sv
// tb/tb_comb_self_test.sv - directed-vector bench for comb_self_test
module tb_comb_self_test;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [2:0] f;
  logic       x, y, z;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] first_fail_idx;

  int n_vec  = 0;
  int n_miss = 0;

  // 0 good, 1 F1 stuck-at-0, 2 F3 inverted, 3 wrong only at code 6
  int fault_mode = 0;

  comb_self_test #(.SETTLE_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .f              (f),
    .x              (x),
    .y              (y),
    .z              (z),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .fail_valid     (fail_valid),
    .first_fail_idx (first_fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Circuit-under-test model: hand-written truth table plus injected fault
  logic [2:0] good_f;
  always_comb begin
    case ({x, y, z})
      3'd0:    good_f = 3'b101;
      3'd1:    good_f = 3'b000;
      3'd2:    good_f = 3'b010;
      3'd3:    good_f = 3'b010;
      3'd4:    good_f = 3'b010;
      3'd5:    good_f = 3'b100;
      3'd6:    good_f = 3'b001;
      default: good_f = 3'b101;
    endcase
    case (fault_mode)
      1:       f = good_f & 3'b011;
      2:       f = good_f ^ 3'b001;
      3:       f = ({x, y, z} == 3'd6) ? 3'b011 : good_f;
      default: f = good_f;
    endcase
  end

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run: start sampled on edge 0, xyz checked mid-vector, done exactly at edge 24
  task automatic run_sweep(input int mode, input logic [3:0] exp_err,
                           input logic exp_fv, input logic [2:0] exp_idx);
    fault_mode = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (e % 3 == 1) begin
        check_vec($sformatf("xyz_m%0d_e%0d", mode, e), {x, y, z}, (e - 1) / 3);
        check_vec($sformatf("busy_m%0d_e%0d", mode, e), busy, 1);
      end
      if (e == 23) check_vec($sformatf("done_early_m%0d", mode), done, 0);
    end
    check_vec($sformatf("done_m%0d", mode), done, 1);
    check_vec($sformatf("busy_end_m%0d", mode), busy, 0);
    check_vec($sformatf("xyz_end_m%0d", mode), {x, y, z}, 7);
    check_vec($sformatf("err_m%0d", mode), err_count, exp_err);
    check_vec($sformatf("fv_m%0d", mode), fail_valid, exp_fv);
    check_vec($sformatf("ffi_m%0d", mode), first_fail_idx, exp_idx);
    check_vec($sformatf("pass_m%0d", mode), pass, (exp_err == 4'd0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    check_vec("rst_xyz", {x, y, z}, 0);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_done", done, 0);
    check_vec("rst_pass", pass, 0);
    check_vec("rst_err", err_count, 0);
    check_vec("rst_fv", fail_valid, 0);
    check_vec("rst_ffi", first_fail_idx, 0);
    rst = 1'b0;
    tick();

    // abort wins over start in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_vec("abort_prio_busy", busy, 0);

    // Test 1..4: good circuit then faults; each later run restarts from DONE
    run_sweep(0, 4'd0, 1'b0, 3'd0);
    run_sweep(1, 4'd3, 1'b1, 3'd0);
    run_sweep(2, 4'd8, 1'b1, 3'd0);
    run_sweep(3, 4'd1, 1'b1, 3'd6);

    // Test 5: start during busy is ignored, abort at edge 10 clears results
    fault_mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_vec("busy_start_xyz", {x, y, z}, 1);
    check_vec("busy_start_busy", busy, 1);
    for (int e = 6; e <= 9; e++) tick();
    check_vec("pre_abort_err", err_count, 3);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_vec("abort_busy", busy, 0);
    check_vec("abort_xyz", {x, y, z}, 0);
    check_vec("abort_err", err_count, 0);
    check_vec("abort_done", done, 0);
    check_vec("abort_fv", fail_valid, 0);
    tick();
    check_vec("abort_stay_idle", busy, 0);

    // Test 6: async reset mid-SETTLE, then normal runs
    fault_mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    check_vec("pre_rst_xyz", {x, y, z}, 1);
    #2;
    rst = 1'b1;
    #1;
    check_vec("arst_xyz", {x, y, z}, 0);
    check_vec("arst_busy", busy, 0);
    check_vec("arst_err", err_count, 0);
    check_vec("arst_fv", fail_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    run_sweep(0, 4'd0, 1'b0, 3'd0);
    run_sweep(1, 4'd3, 1'b1, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
